// File: rtl/rv32_trap_ctrl_pkg.sv
// Shared types and constants for the RV32 machine-mode trap sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv32_trap_pkg;

    // Trap-entry and MRET sequences share one state register.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EPC,
        ST_CAUSE,
        ST_TVAL,
        ST_STATUS,
        ST_REDIRECT,
        ST_MSTATUS,
        ST_MREDIR
    } state_t;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam logic [4:0] CAUSE_MSI       = 5'd3;
    localparam logic [4:0] CAUSE_MTI       = 5'd7;
    localparam logic [4:0] CAUSE_MEI       = 5'd11;
    localparam logic [4:0] CAUSE_PLAT_BASE = 5'd16;
    localparam logic [4:0] CAUSE_ILLEGAL   = 5'd2;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [1:0] PRIV_M = 2'b11;
    localparam logic [1:0] PRIV_U = 2'b00;

    // Environment calls carry no useful mtval.
    function automatic logic is_ecall(input logic [4:0] code);
        return (code == 5'd8) || (code == 5'd9) || (code == 5'd11);
    endfunction

endpackage

// File: rtl/rv32_trap_ctrl_if.sv
// Pipeline and CSR-file side signals of the trap sequencer.
// Latency: n/a (wiring only).
// Backpressure: stall tells the core to hold while a sequence runs.
interface rv32_trap_ctrl_if #(parameter int NUM_PLAT_IRQ = 8);
    logic                    exc_valid;
    logic [4:0]              exc_cause;
    logic [31:0]             exc_tval;
    logic [31:0]             cur_pc;
    logic                    instr_boundary;
    logic                    mret;
    logic                    irq_meip;
    logic                    irq_mtip;
    logic                    irq_msip;
    logic [NUM_PLAT_IRQ-1:0] plat_irq;
    logic [31:0]             mstatus_i;
    logic [31:0]             mie_i;
    logic [31:0]             mtvec_i;
    logic [31:0]             mepc_i;
    logic                    csr_we;
    logic [11:0]             csr_addr;
    logic [31:0]             csr_wdata;
    logic                    redirect_valid;
    logic [31:0]             redirect_pc;
    logic                    stall;
    logic [1:0]              priv_o;
    logic                    trap_active;

    modport master (
        output exc_valid, exc_cause, exc_tval, cur_pc, instr_boundary, mret,
               irq_meip, irq_mtip, irq_msip, plat_irq,
               mstatus_i, mie_i, mtvec_i, mepc_i,
        input  csr_we, csr_addr, csr_wdata, redirect_valid, redirect_pc,
               stall, priv_o, trap_active
    );

    modport slave (
        input  exc_valid, exc_cause, exc_tval, cur_pc, instr_boundary, mret,
               irq_meip, irq_mtip, irq_msip, plat_irq,
               mstatus_i, mie_i, mtvec_i, mepc_i,
        output csr_we, csr_addr, csr_wdata, redirect_valid, redirect_pc,
               stall, priv_o, trap_active
    );
endinterface

// File: rtl/rv32_trap_ctrl_irq_prio.sv
// Fixed-priority interrupt picker: platform (lowest index) > MEI > MSI > MTI.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides whether to take the interrupt.
module rv32_irq_prio
    import rv32_trap_pkg::*;
#(
    parameter int NUM_PLAT_IRQ = 8
) (
    // Packed as {plat[N-1:0], meip, mtip, msip}
    input  logic [NUM_PLAT_IRQ+2:0] pending,
    input  logic [NUM_PLAT_IRQ+2:0] enable,
    output logic                    irq_valid,
    output logic [4:0]              irq_cause
);
    localparam int IDX_MSI  = 0;
    localparam int IDX_MTI  = 1;
    localparam int IDX_MEI  = 2;
    localparam int IDX_PLAT = 3;

    logic [NUM_PLAT_IRQ+2:0] active;

    assign active    = pending & enable;
    assign irq_valid = |active;

    // Later assignments override earlier ones, so the list runs lowest priority first.
    always_comb begin
        irq_cause = 5'd0;
        if (active[IDX_MTI]) irq_cause = CAUSE_MTI;
        if (active[IDX_MSI]) irq_cause = CAUSE_MSI;
        if (active[IDX_MEI]) irq_cause = CAUSE_MEI;
        for (int i = NUM_PLAT_IRQ - 1; i >= 0; i--) begin
            if (active[IDX_PLAT + i]) irq_cause = CAUSE_PLAT_BASE + 5'(i);
        end
    end
endmodule

// File: rtl/rv32_trap_ctrl.sv
// Trap/MRET sequencer: arbitrates exceptions vs interrupts vs MRET, writes CSRs, redirects fetch.
// Latency: trap accept N -> redirect N+5; MRET accept N -> redirect N+2. Vectored mode: RV32_TRAP_CTRL_VECTORED_EN.
// Backpressure: stall=1 outside IDLE; events offered then are dropped and must be re-presented.
module rv32_trap_ctrl
    import rv32_trap_pkg::*;
#(
    parameter int         NUM_PLAT_IRQ = 8,
    parameter logic [1:0] RESET_PRIV   = 2'b11
) (
    input  logic clk,
    input  logic reset,
    rv32_trap_ctrl_if.slave bus
);
    state_t      state, state_nxt;
    logic [31:0] lat_pc, lat_cause, lat_tval;
    logic        accept_trap;
    logic [31:0] acc_cause, acc_tval;
    logic        irq_valid, irq_take;
    logic [4:0]  irq_cause;
    logic [1:0]  priv_q, mpp_ret;
    logic        trap_q;
    logic [31:0] status_trap, status_mret, trap_target;
    logic        csr_we, redirect_valid;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, redirect_pc;

    rv32_irq_prio #(.NUM_PLAT_IRQ(NUM_PLAT_IRQ)) u_prio (
        .pending   ({bus.plat_irq, bus.irq_meip, bus.irq_mtip, bus.irq_msip}),
        .enable    ({bus.mie_i[CAUSE_PLAT_BASE +: NUM_PLAT_IRQ], bus.mie_i[CAUSE_MEI],
                     bus.mie_i[CAUSE_MTI], bus.mie_i[CAUSE_MSI]}),
        .irq_valid (irq_valid),
        .irq_cause (irq_cause)
    );

    // U-mode is always interruptible by M-level interrupts; M-mode only with MIE set.
    assign irq_take = bus.instr_boundary && irq_valid
                   && (bus.mstatus_i[MSTATUS_MIE] || priv_q == PRIV_U);

    // mstatus images for trap entry and MRET, built from the live CSR value.
    always_comb begin
        status_trap                                 = bus.mstatus_i;
        status_trap[MSTATUS_MPIE]                   = bus.mstatus_i[MSTATUS_MIE];
        status_trap[MSTATUS_MIE]                    = 1'b0;
        status_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = priv_q;
        status_mret                                 = bus.mstatus_i;
        status_mret[MSTATUS_MIE]                    = bus.mstatus_i[MSTATUS_MPIE];
        status_mret[MSTATUS_MPIE]                   = 1'b1;
        status_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = PRIV_U;
        // Only M and U exist; any other MPP encoding returns to U.
        mpp_ret = (bus.mstatus_i[MSTATUS_MPP_HI:MSTATUS_MPP_LO] == PRIV_M) ? PRIV_M : PRIV_U;
    end

    // Trap vector: base address, optionally offset by cause for interrupts in vectored mode.
    always_comb begin
        trap_target = {bus.mtvec_i[31:2], 2'b00};
`ifdef RV32_TRAP_CTRL_VECTORED_EN
        if (lat_cause[31] && bus.mtvec_i[1:0] == 2'b01)
            trap_target = trap_target + {25'd0, lat_cause[4:0], 2'b00};
`endif
    end

`ifndef RV32_TRAP_CTRL_VECTORED_EN
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = ^bus.mtvec_i[1:0];
`endif

    // Next-state, arbitration and per-state CSR/redirect outputs.
    always_comb begin
        state_nxt      = state;
        accept_trap    = 1'b0;
        acc_cause      = 32'd0;
        acc_tval       = 32'd0;
        csr_we         = 1'b0;
        csr_addr       = 12'd0;
        csr_wdata      = 32'd0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        unique case (state)
            ST_IDLE: begin
                if (bus.exc_valid) begin
                    accept_trap = 1'b1;
                    acc_cause   = {27'd0, bus.exc_cause};
                    acc_tval    = is_ecall(bus.exc_cause) ? 32'd0 : bus.exc_tval;
                end else if (irq_take) begin
                    accept_trap = 1'b1;
                    acc_cause   = {1'b1, 26'd0, irq_cause};
                end else if (bus.mret) begin
                    if (priv_q == PRIV_U) begin
                        accept_trap = 1'b1;
                        acc_cause   = {27'd0, CAUSE_ILLEGAL};
                    end else begin
                        state_nxt = ST_MSTATUS;
                    end
                end
                if (accept_trap) state_nxt = ST_EPC;
            end
            ST_EPC: begin
                csr_we    = 1'b1;
                csr_addr  = CSR_MEPC;
                csr_wdata = lat_pc & ~32'd3;
                state_nxt = ST_CAUSE;
            end
            ST_CAUSE: begin
                csr_we    = 1'b1;
                csr_addr  = CSR_MCAUSE;
                csr_wdata = lat_cause;
                state_nxt = ST_TVAL;
            end
            ST_TVAL: begin
                csr_we    = 1'b1;
                csr_addr  = CSR_MTVAL;
                csr_wdata = lat_tval;
                state_nxt = ST_STATUS;
            end
            ST_STATUS: begin
                csr_we    = 1'b1;
                csr_addr  = CSR_MSTATUS;
                csr_wdata = status_trap;
                state_nxt = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = trap_target;
                state_nxt      = ST_IDLE;
            end
            ST_MSTATUS: begin
                csr_we    = 1'b1;
                csr_addr  = CSR_MSTATUS;
                csr_wdata = status_mret;
                state_nxt = ST_MREDIR;
            end
            ST_MREDIR: begin
                redirect_valid = 1'b1;
                redirect_pc    = bus.mepc_i;
                state_nxt      = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset abandons any sequence in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Capture the accepted event so later CSR writes do not depend on the core holding it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_pc    <= 32'd0;
            lat_cause <= 32'd0;
            lat_tval  <= 32'd0;
        end else if (accept_trap) begin
            lat_pc    <= bus.cur_pc;
            lat_cause <= acc_cause;
            lat_tval  <= acc_tval;
        end
    end

    // Privilege and trap_active change only at the end of the redirect-side states.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            priv_q <= RESET_PRIV;
            trap_q <= 1'b0;
        end else begin
            if (state == ST_REDIRECT) begin
                priv_q <= PRIV_M;
                trap_q <= 1'b1;
            end
            if (state == ST_MSTATUS) priv_q <= mpp_ret;
            if (state == ST_MREDIR)  trap_q <= 1'b0;
        end
    end

    assign bus.csr_we         = csr_we;
    assign bus.csr_addr       = csr_addr;
    assign bus.csr_wdata      = csr_wdata;
    assign bus.redirect_valid = redirect_valid;
    assign bus.redirect_pc    = redirect_pc;
    assign bus.stall          = (state != ST_IDLE);
    assign bus.priv_o         = priv_q;
    assign bus.trap_active    = trap_q;
endmodule

// File: tb/tb_rv32_trap_ctrl.sv
// Randomized and directed bench for rv32_trap_ctrl against a queue-based behavioural model.
// Latency: model expands each accepted event into its per-cycle output records.
// Backpressure: CSR inputs are held while the model says a sequence is running.
`timescale 1ns/1ps
module tb_rv32_trap_ctrl;
    localparam int NPI = 8;

    typedef struct {
        bit            reset, exc, mret, bnd, meip, mtip, msip;
        bit [4:0]      cause;
        bit [31:0]     tval, pc, mstatus, mie, mtvec, mepc;
        bit [NPI-1:0]  plat;
    } in_t;

    typedef struct {
        bit        we;
        bit [11:0] addr;
        bit [31:0] wdata;
        bit        rv;
        bit [31:0] rpc;
        bit        set_priv;
        bit [1:0]  priv;
        bit        set_trap;
        bit        trap;
    } rec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rv32_trap_ctrl_if #(.NUM_PLAT_IRQ(NPI)) bus();
    rv32_trap_ctrl #(.NUM_PLAT_IRQ(NPI), .RESET_PRIV(2'b11)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    in_t       nx;
    rec_t      exp_q[$];
    rec_t      cur;
    bit        have_cur;
    bit [1:0]  m_priv;
    bit        m_trap;
    bit        e_rst, chk_en;
    int        cyc, acc_cyc;
    int        n_pass, n_total;
    logic [11:0] lg_addr[$];
    logic [31:0] lg_data[$];
    logic [31:0] lg_rpc;
    int        lg_nredir, lg_redir_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic drive();
        reset              = nx.reset;
        bus.exc_valid      = nx.exc;
        bus.exc_cause      = nx.cause;
        bus.exc_tval       = nx.tval;
        bus.cur_pc         = nx.pc;
        bus.instr_boundary = nx.bnd;
        bus.mret           = nx.mret;
        bus.irq_meip       = nx.meip;
        bus.irq_mtip       = nx.mtip;
        bus.irq_msip       = nx.msip;
        bus.plat_irq       = nx.plat;
        bus.mstatus_i      = nx.mstatus;
        bus.mie_i          = nx.mie;
        bus.mtvec_i        = nx.mtvec;
        bus.mepc_i         = nx.mepc;
    endtask

    // Interrupt chosen by walking the priority list in order; -1 when none is pending and enabled.
    function automatic int irq_pick();
        int order[$];
        bit p;
        for (int i = 0; i < NPI; i++) order.push_back(16 + i);
        order.push_back(11);
        order.push_back(3);
        order.push_back(7);
        foreach (order[k]) begin
            case (order[k])
                11:      p = nx.meip;
                3:       p = nx.msip;
                7:       p = nx.mtip;
                default: p = nx.plat[order[k] - 16];
            endcase
            if (p && nx.mie[order[k]]) return order[k];
        end
        return -1;
    endfunction

    task automatic push_trap(input bit [31:0] cause, input bit [31:0] tval);
        rec_t r;
        bit [31:0] st, tgt;
        st = nx.mstatus;
        st[7] = nx.mstatus[3];
        st[3] = 1'b0;
        st[12:11] = m_priv;
        tgt = {nx.mtvec[31:2], 2'b00};
`ifdef RV32_TRAP_CTRL_VECTORED_EN
        if (cause[31] && nx.mtvec[1:0] == 2'b01) tgt = tgt + 4 * cause[4:0];
`endif
        r = '{default: 0}; r.we = 1; r.addr = 12'h341; r.wdata = nx.pc & ~32'd3; exp_q.push_back(r);
        r = '{default: 0}; r.we = 1; r.addr = 12'h342; r.wdata = cause;          exp_q.push_back(r);
        r = '{default: 0}; r.we = 1; r.addr = 12'h343; r.wdata = tval;           exp_q.push_back(r);
        r = '{default: 0}; r.we = 1; r.addr = 12'h300; r.wdata = st;             exp_q.push_back(r);
        r = '{default: 0}; r.rv = 1; r.rpc = tgt;
        r.set_priv = 1; r.priv = 2'b11; r.set_trap = 1; r.trap = 1;
        exp_q.push_back(r);
        acc_cyc = cyc;
    endtask

    task automatic push_mret();
        rec_t r;
        bit [31:0] st;
        st = nx.mstatus;
        st[3] = nx.mstatus[7];
        st[7] = 1'b1;
        st[12:11] = 2'b00;
        r = '{default: 0}; r.we = 1; r.addr = 12'h300; r.wdata = st;
        r.set_priv = 1; r.priv = (nx.mstatus[12:11] == 2'b11) ? 2'b11 : 2'b00;
        exp_q.push_back(r);
        r = '{default: 0}; r.rv = 1; r.rpc = nx.mepc; r.set_trap = 1; r.trap = 0;
        exp_q.push_back(r);
        acc_cyc = cyc;
    endtask

    task automatic model_eval();
        int c;
        if (exp_q.size() > 0) begin
            cur = exp_q[0];
            have_cur = 1;
        end else begin
            have_cur = 0;
            cur = '{default: 0};
            if (!nx.reset) begin
                c = irq_pick();
                if (nx.exc)
                    push_trap({27'd0, nx.cause}, (nx.cause inside {5'd8, 5'd9, 5'd11}) ? 32'd0 : nx.tval);
                else if (c >= 0 && nx.bnd && (nx.mstatus[3] || m_priv == 2'b00))
                    push_trap(32'h8000_0000 | 32'(c), 32'd0);
                else if (nx.mret) begin
                    if (m_priv == 2'b00) push_trap(32'd2, 32'd0);
                    else                 push_mret();
                end
            end
        end
        e_rst = nx.reset;
    endtask

    // One clock: retire last cycle's record, drive this cycle's inputs, form expectations.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (have_cur) begin
            if (cur.set_priv) m_priv = cur.priv;
            if (cur.set_trap) m_trap = cur.trap;
            exp_q.delete(0);
            have_cur = 0;
        end
        drive();
        if (nx.reset) begin
            exp_q.delete();
            m_priv = 2'b11;
            m_trap = 0;
        end
        model_eval();
    endtask

    // Compare DUT outputs with the model every cycle, mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", bus.stall, have_cur);
            chk("priv_o", bus.priv_o, m_priv);
            chk("trap_active", bus.trap_active, m_trap);
            chk("csr_we", bus.csr_we, cur.we);
            chk("redirect_valid", bus.redirect_valid, cur.rv);
            if (cur.we) begin
                chk("csr_addr", bus.csr_addr, cur.addr);
                chk("csr_wdata", bus.csr_wdata, cur.wdata);
            end
            if (cur.rv) chk("redirect_pc", bus.redirect_pc, cur.rpc);
            if (e_rst) begin
                chk("rst_csr_addr", bus.csr_addr, 0);
                chk("rst_csr_wdata", bus.csr_wdata, 0);
                chk("rst_redirect_pc", bus.redirect_pc, 0);
            end
            if (bus.csr_we) begin
                lg_addr.push_back(bus.csr_addr);
                lg_data.push_back(bus.csr_wdata);
            end
            if (bus.redirect_valid) begin
                lg_rpc = bus.redirect_pc;
                lg_nredir++;
                lg_redir_cyc = cyc;
            end
        end
    end

    task automatic idle_in();
        nx.exc = 0; nx.mret = 0; nx.bnd = 1;
        nx.meip = 0; nx.mtip = 0; nx.msip = 0; nx.plat = '0;
    endtask

    task automatic clr_log();
        lg_addr.delete();
        lg_data.delete();
        lg_nredir = 0;
        lg_rpc = 32'hx;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        nx.reset = 1;
        run(2);
        nx.reset = 0;
        step();
    endtask

    // Literal check of the idx-th logged CSR write.
    task automatic exp_wr(input string name, input int idx, input logic [11:0] a, input logic [31:0] d);
        logic [11:0] ga;
        logic [31:0] gd;
        ga = (idx < lg_addr.size()) ? lg_addr[idx] : 12'hxxx;
        gd = (idx < lg_data.size()) ? lg_data[idx] : 32'hxxxxxxxx;
        chk({name, "_addr"}, ga, a);
        chk({name, "_data"}, gd, d);
    endtask

    initial begin
        nx = '{default: 0};
        nx.reset = 1;
        nx.bnd = 1;
        drive();
        m_priv = 2'b11; m_trap = 0; have_cur = 0; cur = '{default: 0}; e_rst = 1;
        n_pass = 0; n_total = 0; cyc = 0; acc_cyc = 0;
        clr_log();
        chk_en = 1;
        run(2);
        nx.reset = 0;
        step();

        // Exception with full field check.
        idle_in(); nx.mstatus = 32'h88; nx.mtvec = 32'h10000; nx.mie = 0; nx.mepc = 0;
        clr_log();
        nx.exc = 1; nx.cause = 2; nx.tval = 32'hDEADBEEF; nx.pc = 32'h100;
        step();
        nx.exc = 0;
        run(7);
        chk("exc_nwr", lg_addr.size(), 4);
        exp_wr("exc_epc", 0, 12'h341, 32'h100);
        exp_wr("exc_cause", 1, 12'h342, 32'h2);
        exp_wr("exc_tval", 2, 12'h343, 32'hDEADBEEF);
        exp_wr("exc_status", 3, 12'h300, 32'h1880);
        chk("exc_rpc", lg_rpc, 32'h10000);
        chk("exc_latency", lg_redir_cyc - acc_cyc, 5);

        // MRET back to U-mode.
        idle_in(); nx.mstatus = 32'h80; nx.mepc = 32'h200;
        clr_log();
        nx.mret = 1;
        step();
        nx.mret = 0;
        run(4);
        chk("mret_nwr", lg_addr.size(), 1);
        exp_wr("mret_status", 0, 12'h300, 32'h88);
        chk("mret_rpc", lg_rpc, 32'h200);
        chk("mret_latency", lg_redir_cyc - acc_cyc, 2);
        chk("mret_priv", bus.priv_o, 2'b00);
        chk("mret_trap_active", bus.trap_active, 0);

        // MRET from U-mode becomes an illegal-instruction trap.
        clr_log();
        nx.mret = 1; nx.tval = 32'h1234;
        step();
        nx.mret = 0;
        run(7);
        exp_wr("umret_cause", 1, 12'h342, 32'h2);
        exp_wr("umret_tval", 2, 12'h343, 32'h0);
        exp_wr("umret_status", 3, 12'h300, 32'h0);
        chk("umret_priv", bus.priv_o, 2'b11);

        // Interrupts masked by MIE=0 in M-mode, then MSI beats MTI.
        do_reset();
        idle_in(); nx.mstatus = 32'h0; nx.mie = 32'h88; nx.mtip = 1; nx.msip = 1; nx.mtvec = 32'h10000;
        clr_log();
        run(5);
        chk("irq_masked_nwr", lg_addr.size(), 0);
        chk("irq_masked_stall", bus.stall, 0);
        nx.mstatus = 32'h8;
        step();
        idle_in();
        run(6);
        exp_wr("irq_cause", 1, 12'h342, 32'h80000003);
        exp_wr("irq_tval", 2, 12'h343, 32'h0);
        exp_wr("irq_status", 3, 12'h300, 32'h1880);

        // Platform interrupt, vectored or direct target.
        do_reset();
        idle_in(); nx.plat = 8'h04; nx.mie = 32'h1 << 18; nx.mstatus = 32'h8; nx.mtvec = 32'h10001;
        clr_log();
        step();
        idle_in();
        run(6);
        exp_wr("plat_cause", 1, 12'h342, 32'h80000012);
`ifdef RV32_TRAP_CTRL_VECTORED_EN
        chk("plat_rpc", lg_rpc, 32'h10048);
`else
        chk("plat_rpc", lg_rpc, 32'h10000);
`endif

        // Exception and MRET together, then a new exception during EPC.
        idle_in(); nx.mstatus = 32'h88; nx.mtvec = 32'h10000; nx.mie = 0;
        clr_log();
        nx.exc = 1; nx.cause = 4; nx.tval = 32'h55; nx.pc = 32'h301; nx.mret = 1;
        step();
        nx.mret = 0; nx.cause = 5;
        step();
        nx.exc = 0;
        run(6);
        chk("coll_nwr", lg_addr.size(), 4);
        exp_wr("coll_epc", 0, 12'h341, 32'h300);
        exp_wr("coll_cause", 1, 12'h342, 32'h4);
        exp_wr("coll_tval", 2, 12'h343, 32'h55);
        chk("coll_nredir", lg_nredir, 1);

        // Reset while the sequence would be in CAUSE, then a fresh accept.
        idle_in();
        clr_log();
        nx.exc = 1; nx.cause = 2;
        step();
        nx.exc = 0;
        step();
        do_reset();
        run(3);
        chk("rst_mid_nwr", lg_addr.size(), 1);
        chk("rst_mid_nredir", lg_nredir, 0);
        clr_log();
        nx.exc = 1;
        step();
        nx.exc = 0;
        run(6);
        chk("rst_reaccept_nwr", lg_addr.size(), 4);

        // Randomized traffic; CSR values only change while the model is idle.
        for (int it = 0; it < 800; it++) begin
            if (exp_q.size() == 0) begin
                nx.mstatus = $urandom;
                nx.mie     = $urandom;
                nx.mtvec   = $urandom;
                nx.mepc    = $urandom;
            end
            nx.reset = ($urandom_range(0, 249) == 0);
            nx.exc   = ($urandom_range(0, 9) == 0);
            nx.cause = 5'($urandom_range(0, 15));
            nx.tval  = $urandom;
            nx.pc    = $urandom;
            nx.bnd   = ($urandom_range(0, 3) != 0);
            nx.mret  = ($urandom_range(0, 7) == 0);
            nx.meip  = ($urandom_range(0, 7) == 0);
            nx.mtip  = ($urandom_range(0, 7) == 0);
            nx.msip  = ($urandom_range(0, 7) == 0);
            nx.plat  = NPI'($urandom & $urandom & $urandom & $urandom);
            step();
        end
        nx.reset = 0;
        idle_in();
        run(8);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
